// File: rtl/uart_tx_block.sv
// uart_tx_block: UART transmitter producing start, LSB-first data, optional parity and stop bits.
// Ports:
//   clk        - system clock, rising edge
//   n_rst      - asynchronous active-low reset
//   tx_start   - request to send tx_data; only looked at while idle
//   tx_data    - parallel word, captured on the accepting edge
//   serial_out - registered serial line, idles high
//   tx_busy    - high from the accepting edge until the frame ends
//   tx_done    - one-cycle pulse after the stop bit completes
module uart_tx_block #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_BITS - 1);
  localparam logic          P_ODD   = (PARITY_ODD != 0);
  localparam logic          P_EN    = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap;

  assign serial_out = serial_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign wrap       = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == IDLE) ? '0 : (wrap ? CW'(1) : cnt_q + 1'b1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_start) begin
          // The accepting edge already drives the start bit and counts as its first cycle.
          state_d  = START;
          shift_d  = tx_data;
          par_d    = ^tx_data ^ P_ODD;
          idx_d    = '0;
          cnt_d    = CW'(1);
          serial_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        if (wrap) begin
          state_d  = DATA;
          serial_d = shift_q[0];
        end
      end
      DATA: begin
        if (wrap) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_MAX) begin
            state_d  = P_EN ? PARITY : STOP;
            serial_d = P_EN ? par_q : 1'b1;
          end else begin
            serial_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (wrap) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
      STOP: begin
        if (wrap) begin
          state_d  = IDLE;
          serial_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
